// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the streaming FIR engine.
package fir_pkg;

  localparam int FIR_DATA_W = 32;
  localparam int MAX_TAP    = 16;
  localparam int TAP_IDX_W  = $clog2(MAX_TAP);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_WAIT_X = 3'd2;
  localparam logic [2:0] ST_MAC    = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/fir_mac_unit.sv
// Single shared multiply-accumulate: acc <= acc + a*b each enabled cycle,
// with a synchronous clear that takes priority over the enable.
module fir_mac_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] prod;
  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Only the low W bits of the signed product survive truncation, and those
  // bits are identical for signed and unsigned operands.
  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_stream_core.sv
// Streaming FIR: one sample in, NUM_TAP sequential MACs, one result out.
// Streams use valid/ready: a beat transfers on the rising edge where both are high.
module fir_stream_core
  import fir_pkg::*;
#(
  parameter int NUM_TAP = 11,
  parameter int DATA_W  = FIR_DATA_W
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              cfg_coef_we,
  input  logic [3:0]        cfg_coef_addr,
  input  logic [DATA_W-1:0] cfg_coef_wdata,
  input  logic [31:0]       cfg_len,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              err_tlast,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  input  logic              sm_tready,
  output logic [2:0]        dbg_state_o
);

  logic [2:0]           state_q, state_d;
  logic [TAP_IDX_W-1:0] tap_q, tap_d;
  logic [31:0]          len_q, len_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    coef_q [NUM_TAP];
  logic [DATA_W-1:0]    xbuf_q [NUM_TAP];

  logic in_hs;
  logic last_tap;
  logic coef_wr;
  logic [DATA_W-1:0] acc;

  assign ap_idle   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign ap_done   = (state_q == ST_DONE);
  assign ss_tready = (state_q == ST_WAIT_X);
  assign sm_tvalid = (state_q == ST_OUT);
  assign sm_tlast  = sm_tvalid && (cnt_q == len_q);
  assign sm_tdata  = acc;
  assign err_tlast = err_q;
  assign dbg_state_o = state_q;

  assign in_hs    = ss_tvalid && ss_tready;
  assign last_tap = (tap_q == TAP_IDX_W'(NUM_TAP - 1));
  assign coef_wr  = cfg_coef_we && ap_idle && ({28'd0, cfg_coef_addr} < 32'(NUM_TAP));

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ap_start) begin
          len_d   = cfg_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (cfg_len == 32'd0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_WAIT_X;
      ST_WAIT_X: begin
        if (in_hs) begin
          cnt_d   = cnt_q + 32'd1;
          tap_d   = '0;
          state_d = ST_MAC;
          // tlast is only advisory; a disagreement with the length is flagged.
          if (ss_tlast != ((cnt_q + 32'd1) == len_q)) begin
            err_d = 1'b1;
          end
        end
      end
      ST_MAC: begin
        tap_d = tap_q + 1'b1;
        if (last_tap) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (sm_tready) begin
          state_d = sm_tlast ? ST_DONE : ST_WAIT_X;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < NUM_TAP; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_wr) begin
      coef_q[cfg_coef_addr] <= cfg_coef_wdata;
    end
  end

  // Newest sample sits at index 0 so tap i multiplies x[n-i].
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n || (state_q == ST_CLEAR)) begin
      for (int i = 0; i < NUM_TAP; i++) begin
        xbuf_q[i] <= '0;
      end
    end else if (in_hs) begin
      xbuf_q[0] <= ss_tdata;
      for (int i = 1; i < NUM_TAP; i++) begin
        xbuf_q[i] <= xbuf_q[i-1];
      end
    end
  end

  fir_mac_unit #(
    .W (DATA_W)
  ) u_mac (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .clr_i (in_hs),
    .en_i  (state_q == ST_MAC),
    .a_i   (coef_q[tap_q]),
    .b_i   (xbuf_q[tap_q]),
    .acc_o (acc)
  );

endmodule

// File: tb/tb_fir_stream_core.sv
// Directed/randomized bench for fir_stream_core with a convolution reference model.
module tb_fir_stream_core;

  localparam int NUM_TAP = 11;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        cfg_coef_we;
  logic [3:0]  cfg_coef_addr;
  logic [31:0] cfg_coef_wdata;
  logic [31:0] cfg_len;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic        err_tlast;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] h_m [NUM_TAP];
  logic [31:0] xs [$];
  logic [31:0] exp_q [$];

  fir_stream_core #(.NUM_TAP(NUM_TAP), .DATA_W(32)) dut (
    .axis_clk       (axis_clk),
    .axis_rst_n     (axis_rst_n),
    .cfg_coef_we    (cfg_coef_we),
    .cfg_coef_addr  (cfg_coef_addr),
    .cfg_coef_wdata (cfg_coef_wdata),
    .cfg_len        (cfg_len),
    .ap_start       (ap_start),
    .ap_idle        (ap_idle),
    .ap_done        (ap_done),
    .err_tlast      (err_tlast),
    .ss_tvalid      (ss_tvalid),
    .ss_tdata       (ss_tdata),
    .ss_tlast       (ss_tlast),
    .ss_tready      (ss_tready),
    .sm_tvalid      (sm_tvalid),
    .sm_tdata       (sm_tdata),
    .sm_tlast       (sm_tlast),
    .sm_tready      (sm_tready),
    .dbg_state_o    (dbg_state)
  );

  // Clock
  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: direct convolution over the whole run, x[k<0] = 0.
  function automatic logic [31:0] fir_ref(input int n);
    longint s;
    s = 0;
    for (int i = 0; i < NUM_TAP; i++) begin
      if (n - i >= 0) begin
        s += longint'($signed(h_m[i])) * longint'($signed(xs[n-i]));
      end
    end
    return s[31:0];
  endfunction

  task automatic load_coefs();
    for (int i = 0; i < NUM_TAP; i++) begin
      @(negedge axis_clk);
      cfg_coef_we = 1'b1; cfg_coef_addr = 4'(i); cfg_coef_wdata = h_m[i];
    end
    @(negedge axis_clk);
    cfg_coef_addr = 4'd15; cfg_coef_wdata = $urandom;
    @(negedge axis_clk);
    cfg_coef_we = 1'b0;
  endtask

  task automatic start_run(input int len);
    @(negedge axis_clk);
    cfg_len = 32'(len); ap_start = 1'b1;
    @(negedge axis_clk);
    ap_start = 1'b0;
    chk("start_err_cleared", err_tlast, 0);
    if (len == 0) begin
      chk("len0_done", ap_done, 1);
      for (int k = 0; k < 5; k++) begin
        @(negedge axis_clk);
        chk("len0_no_valid", sm_tvalid, 0);
        chk("len0_no_ready", ss_tready, 0);
      end
    end else begin
      chk("start_done_drop", ap_done, 0);
      chk("start_idle_drop", ap_idle, 0);
    end
  endtask

  task automatic run_stream(input int len, input int bp_at, input int tlast_at, input int disturb_at);
    logic exp_err;
    logic last;
    logic [31:0] held;
    int w;
    exp_err = 1'b0;
    exp_q.delete();
    for (int n = 0; n < len; n++) exp_q.push_back(fir_ref(n));
    for (int n = 0; n < len; n++) begin
      last = (tlast_at >= 0) ? (n == tlast_at) : (n == len - 1);
      if (last != (n == len - 1)) exp_err = 1'b1;
      ss_tvalid = 1'b1; ss_tdata = xs[n]; ss_tlast = last;
      w = 0;
      while (!ss_tready && w < 100) begin
        @(negedge axis_clk);
        w++;
      end
      chk("in_accept_timeout", 32'(w < 100), 1);
      @(negedge axis_clk);
      ss_tvalid = 1'b0; ss_tlast = 1'b0;
      w = 0;
      if (n == disturb_at) begin
        cfg_coef_we = 1'b1; cfg_coef_addr = 4'd0; cfg_coef_wdata = 32'h5555_5555;
        ap_start = 1'b1; cfg_len = 32'd3;
        @(negedge axis_clk);
        cfg_coef_we = 1'b0; ap_start = 1'b0;
        w = 1;
      end
      while (!sm_tvalid && w < 100) begin
        @(negedge axis_clk);
        w++;
      end
      chk("latency", 32'(w), 32'(NUM_TAP));
      if (n == bp_at) begin
        held = sm_tdata;
        for (int k = 0; k < 20; k++) begin
          @(negedge axis_clk);
          chk("bp_valid", sm_tvalid, 1);
          chk("bp_data", sm_tdata, held);
          chk("bp_ss_tready", ss_tready, 0);
        end
      end
      chk("y", sm_tdata, exp_q.pop_front());
      chk("tlast", sm_tlast, 32'(n == len - 1));
      sm_tready = 1'b1;
      @(negedge axis_clk);
      sm_tready = 1'b0;
    end
    chk("end_done", ap_done, 1);
    chk("end_idle", ap_idle, 1);
    chk("end_no_valid", sm_tvalid, 0);
    chk("err_tlast", err_tlast, exp_err);
  endtask

  task automatic set_impulse_h();
    int imp [NUM_TAP] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < NUM_TAP; i++) h_m[i] = imp[i];
  endtask

  task automatic set_impulse_x(input int len);
    xs.delete();
    for (int n = 0; n < len; n++) xs.push_back((n == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    axis_rst_n = 1'b0; cfg_coef_we = 1'b0; cfg_coef_addr = '0; cfg_coef_wdata = '0;
    cfg_len = '0; ap_start = 1'b0; ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
    sm_tready = 1'b0;
    repeat (3) @(negedge axis_clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_err", err_tlast, 0);
    chk("rst_ss_tready", ss_tready, 0);
    chk("rst_sm_tvalid", sm_tvalid, 0);
    chk("rst_sm_tdata", sm_tdata, 0);
    chk("rst_sm_tlast", sm_tlast, 0);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    // Impulse response
    set_impulse_h();
    load_coefs();
    set_impulse_x(11);
    start_run(11);
    run_stream(11, -1, -1, -1);

    // Ramp, three back-to-back runs; the middle one is disturbed mid-MAC
    xs.delete();
    for (int n = 0; n < 600; n++) xs.push_back(32'(n));
    for (int r = 0; r < 3; r++) begin
      start_run(600);
      run_stream(600, -1, -1, (r == 1) ? 5 : -1);
    end

    // Random coefficients and samples with a 20-cycle output stall
    for (int i = 0; i < NUM_TAP; i++) h_m[i] = $urandom;
    load_coefs();
    xs.delete();
    for (int n = 0; n < 40; n++) xs.push_back($urandom);
    start_run(40);
    run_stream(40, 17, -1, -1);

    // Small signed random values, wrong tlast position
    for (int i = 0; i < NUM_TAP; i++) h_m[i] = 32'($urandom_range(0, 200)) - 32'd100;
    load_coefs();
    xs.delete();
    for (int n = 0; n < 10; n++) xs.push_back(32'($urandom_range(0, 2000)) - 32'd1000);
    start_run(10);
    run_stream(10, -1, 4, -1);

    // Wrap-around of the truncated product
    for (int i = 0; i < NUM_TAP; i++) h_m[i] = (i == 0) ? 32'h7FFF_FFFF : 32'd0;
    load_coefs();
    xs.delete();
    xs.push_back(32'd2);
    start_run(1);
    run_stream(1, -1, -1, -1);

    // Reset in the middle of MAC
    set_impulse_h();
    load_coefs();
    set_impulse_x(11);
    start_run(11);
    ss_tvalid = 1'b1; ss_tdata = 32'd1; ss_tlast = 1'b0;
    begin
      int w = 0;
      while (!ss_tready && w < 100) begin
        @(negedge axis_clk);
        w++;
      end
      chk("rst_mid_accept", 32'(w < 100), 1);
    end
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
    repeat (3) @(negedge axis_clk);
    axis_rst_n = 1'b0;
    @(negedge axis_clk);
    chk("midrst_idle", ap_idle, 1);
    chk("midrst_done", ap_done, 0);
    chk("midrst_sm_tvalid", sm_tvalid, 0);
    chk("midrst_sm_tdata", sm_tdata, 0);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    // Zero-length run straight from IDLE
    start_run(0);

    // Coefficients are cleared by reset, so the impulse yields zeros
    for (int i = 0; i < NUM_TAP; i++) h_m[i] = 32'd0;
    set_impulse_x(11);
    start_run(11);
    run_stream(11, -1, -1, -1);

    // Reloaded coefficients give the impulse response again
    set_impulse_h();
    load_coefs();
    start_run(11);
    run_stream(11, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
